// File: rtl/div_seq_if.sv
// Operand/result bundle for div_seq: the master issues start and operands,
// and the slave returns busy, valid and the held results.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             iStart;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iSigned;
    logic             oBusy;
    logic             oValid;
    logic [WIDTH-1:0] oQ;
    logic [WIDTH-1:0] oR;
    logic             oDivZero;

    modport master (
        output iStart, iA, iB, iSigned,
        input  oBusy, oValid, oQ, oR, oDivZero
    );

    modport slave (
        input  iStart, iA, iB, iSigned,
        output oBusy, oValid, oQ, oR, oDivZero
    );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle and a fixed WIDTH+2 cycle latency.
// Define DIV_SEQ_SIGNED_EN to enable two's-complement operation selected by iSigned.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic     iClk,
    input  logic     iRst,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz_out;
    logic             r_valid;

    logic             w_accept;
    logic             w_busy;
    logic             w_load;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    // NOTE: sequential state always uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge iClk) begin
        if (iRst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned and infers a latch.
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: if (bus.iStart) w_next = S_CALC;
            S_CALC:         if (w_last) w_next = S_FIN;
            S_FIN:          w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_busy   = 1'b0;
        w_load   = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: w_accept = bus.iStart && !iRst;
            S_CALC:         w_busy   = 1'b1;
            S_FIN: begin
                w_busy = 1'b1;
                w_load = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_last  = (r_cnt == '0);
    // Partial remainder is WIDTH+1 bits wide only at the compare; after it, it always fits WIDTH bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[WIDTH-1:0] - r_div;

`ifdef DIV_SEQ_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_a_raw;
    logic             w_sgn_a;
    logic             w_sgn_b;

    assign w_sgn_a = bus.iSigned & bus.iA[WIDTH-1];
    assign w_sgn_b = bus.iSigned & bus.iB[WIDTH-1];
    assign w_a_in  = w_sgn_a ? -bus.iA : bus.iA;
    assign w_b_in  = w_sgn_b ? -bus.iB : bus.iB;

    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_neg_q <= w_sgn_a ^ w_sgn_b;
            r_neg_r <= w_sgn_a;
            r_a_raw <= bus.iA;
        end
    end

    // Divide-by-zero bypasses sign correction so the raw dividend comes back untouched.
    assign w_q_fin = r_dz ? '1      : (r_neg_q ? -r_quo : r_quo);
    assign w_r_fin = r_dz ? r_a_raw : (r_neg_r ? -r_rem : r_rem);
`else
    assign w_a_in  = bus.iA;
    assign w_b_in  = bus.iB;
    assign w_q_fin = r_quo;
    assign w_r_fin = r_rem;
`endif

    // NOTE: working registers are don't-care until a start loads them, so they carry no reset.
    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_quo <= w_a_in;
            r_div <= w_b_in;
            r_rem <= '0;
            r_cnt <= CW'(WIDTH - 1);
            r_dz  <= (bus.iB == '0);
        end else if (r_state == S_CALC) begin
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_q      <= '0;
            r_r      <= '0;
            r_dz_out <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_q      <= w_q_fin;
                r_r      <= w_r_fin;
                r_dz_out <= r_dz;
            end else if (w_accept) begin
                r_dz_out <= 1'b0;
            end
        end
    end

    assign bus.oBusy    = w_busy;
    assign bus.oValid   = r_valid;
    assign bus.oQ       = r_q;
    assign bus.oR       = r_r;
    assign bus.oDivZero = r_dz_out;
endmodule
